prefetch_fetch: RTL and testbench

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue, sitting between the instruction port of `main_memory` and decode in the 5-stage RV32I pipeline. It fetches sequentially ahead of decode, holding at most one memory request in flight. It absorbs decode stalls without dropping bandwidth and services PC redirects from execute and writeback. On a flush it rewinds and refetches from the oldest unconsumed instruction.

---
 rtl/prefetch_fetch.sv | 106 ++++++++++
 tb/tb_prefetch_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_fetch.sv
// prefetch_fetch: sequential instruction prefetch into a small queue with redirect/flush replay
module prefetch_fetch #(
    parameter logic [31:0] PC_RESET = 32'h1000,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                main_memory_instr_addr,
    output logic                       main_memory_instr_req,
    input  logic                       main_memory_instr_ack,
    input  logic [31:0]                main_memory_instr,
    output logic [31:0]                fetch_instr,
    output logic [31:0]                pc,
    output logic                       fetch_valid,
    output logic                       next_clk_en,
    output logic [$clog2(DEPTH):0]     occupancy,
    input  logic                       writeback_change_pc,
    input  logic [31:0]                writeback_next_pc,
    input  logic                       execute_change_pc,
    input  logic [31:0]                execute_next_pc,
    input  logic                       stall,
    input  logic                       flush
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d, addr_q, addr_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0] cnt_q, cnt_d, cnt_n;
    logic [31:0] qpc_q  [DEPTH];
    logic [31:0] qins_q [DEPTH];
    logic        redir, clr, ack, push, pop;
    logic [31:0] tgt;

    assign redir = writeback_change_pc | execute_change_pc;
    assign tgt   = (writeback_change_pc ? writeback_next_pc : execute_next_pc) & ~32'd3;
    assign clr   = redir | flush;
    assign ack   = main_memory_instr_ack & (state_q != IDLE);
    assign push  = (state_q == REQ) & ack & ~clr;
    assign pop   = fetch_valid & ~stall & ~clr;
    assign cnt_n = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    assign fetch_valid            = cnt_q != '0;
    assign next_clk_en            = pop;
    assign fetch_instr            = fetch_valid ? qins_q[rd_q] : NOP;
    assign pc                     = fetch_valid ? qpc_q[rd_q] : fpc_q;
    assign occupancy              = cnt_q;
    assign main_memory_instr_req  = state_q != IDLE;
    assign main_memory_instr_addr = addr_q;

    // Next state: clear/rewind on redirect or flush; otherwise request while there is room
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        addr_d  = addr_q;
        rd_d    = rd_q + AW'(pop);
        wr_d    = wr_q + AW'(push);
        cnt_d   = cnt_n;
        if (clr) begin
            rd_d    = '0;
            wr_d    = '0;
            cnt_d   = '0;
            fpc_d   = redir ? tgt : (fetch_valid ? qpc_q[rd_q] : fpc_q);
            state_d = (state_q == IDLE || ack) ? REQ : DROP;
            addr_d  = (state_q == IDLE || ack) ? fpc_d : addr_q;
        end else if (state_q == IDLE) begin
            state_d = (cnt_q < FULL) ? REQ : IDLE;
            addr_d  = fpc_q;
        end else if (ack) begin
            state_d = (state_q == DROP || cnt_n < FULL) ? REQ : IDLE;
            fpc_d   = (state_q == REQ) ? fpc_q + 32'd4 : fpc_q;
            addr_d  = fpc_d;
        end
    end

    // Control registers, cleared immediately on reset so a late ack finds req low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            fpc_q   <= PC_RESET;
            addr_q  <= PC_RESET;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Queue storage; contents are only observed through the count so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            qpc_q[wr_q]  <= fpc_q;
            qins_q[wr_q] <= main_memory_instr;
        end
    end
endmodule

// File: tb/tb_prefetch_fetch.sv
// tb_prefetch_fetch: directed scenarios with a pop-order scoreboard
module tb_prefetch_fetch;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] addr, mem_instr, fetch_instr, pc, wb_pc = 0, ex_pc = 0;
    logic        req, ack, fetch_valid, next_clk_en;
    logic        wb_chg = 0, ex_chg = 0, stall = 0, flush = 0;
    logic [2:0]  occupancy;
    logic        ack_q = 0, extra_ack = 0;
    int          lat = 1, n = 0;
    int          checks = 0, failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
    endfunction

    assign mem_instr = word(addr);
    assign ack       = ack_q | extra_ack;

    // Memory model: acks after lat cycles of continuous request
    always @(posedge clk) begin
        if (req) begin
            if (n + 1 >= lat) begin
                ack_q <= 1'b1;
                n     <= 0;
            end else begin
                ack_q <= 1'b0;
                n     <= n + 1;
            end
        end else begin
            ack_q <= 1'b0;
            n     <= 0;
        end
    end

    prefetch_fetch dut (
        .clk(clk), .rst(rst),
        .main_memory_instr_addr(addr), .main_memory_instr_req(req),
        .main_memory_instr_ack(ack), .main_memory_instr(mem_instr),
        .fetch_instr(fetch_instr), .pc(pc), .fetch_valid(fetch_valid),
        .next_clk_en(next_clk_en), .occupancy(occupancy),
        .writeback_change_pc(wb_chg), .writeback_next_pc(wb_pc),
        .execute_change_pc(ex_chg), .execute_next_pc(ex_pc),
        .stall(stall), .flush(flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every consumed instruction must be the next expected one
    always @(negedge clk) begin
        if (rst && next_clk_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=%h required=none", pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", pc, e);
                chk("pop_instr", fetch_instr, word(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_range(input logic [31:0] lo, input int cnt);
        for (int i = 0; i < cnt; i++) exp_q.push_back(lo + 32'(4 * i));
    endtask

    task automatic run_until(input logic [31:0] target);
        for (int k = 0; k < 100; k++) begin
            tick();
            if (fetch_valid && pc == target) return;
        end
        chk("timeout_pc", pc, target);
    endtask

    task automatic wait_pending();
        for (int k = 0; k < 20; k++) begin
            tick();
            if (req && !ack) return;
        end
        chk("timeout_pending", 32'(ack), 32'd0);
    endtask

    initial begin
        #2 rst = 0;
        @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", addr, 32'h1000);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_instr", fetch_instr, 32'h13);
        chk("rst_pc", pc, 32'h1000);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_nce", 32'(next_clk_en), 32'd0);
        @(posedge clk);
        #1 rst = 1;
        expect_range(32'h1000, 10);
        tick();
        chk("first_req", 32'(req), 32'd1);
        chk("first_addr", addr, 32'h1000);
        chk("valid_c1", 32'(fetch_valid), 32'd0);
        tick();
        chk("valid_c2", 32'(fetch_valid), 32'd0);
        tick();
        chk("valid_c3", 32'(fetch_valid), 32'd1);
        chk("pc_c3", pc, 32'h1000);
        run_until(32'h1028);
        // stall until the queue saturates
        stall = 1;
        expect_range(32'h1028, 8);
        repeat (10) tick();
        chk("sat_occ", 32'(occupancy), 32'd4);
        chk("sat_req", 32'(req), 32'd0);
        chk("sat_pc", pc, 32'h1028);
        chk("sat_instr", fetch_instr, word(32'h1028));
        stall = 0;
        for (int k = 0; k < 20 && !req; k++) tick();
        chk("resume_addr", addr, 32'h1038);
        run_until(32'h1048);
        // execute redirect while a request is pending
        stall = 1;
        lat = 2;
        wait_pending();
        ex_chg = 1;
        ex_pc = 32'h1040;
        tick();
        ex_chg = 0;
        chk("redir_valid", 32'(fetch_valid), 32'd0);
        chk("redir_occ", 32'(occupancy), 32'd0);
        chk("drop_req", 32'(req), 32'd1);
        chk("drop_addr", addr, 32'h1050);
        for (int k = 0; k < 20 && addr == 32'h1050; k++) tick();
        chk("redir_addr", addr, 32'h1040);
        lat = 1;
        expect_range(32'h1040, 4);
        stall = 0;
        run_until(32'h1050);
        // simultaneous redirects: writeback wins
        expect_range(32'h2000, 2);
        wb_chg = 1;
        wb_pc = 32'h2000;
        ex_chg = 1;
        ex_pc = 32'h3000;
        tick();
        wb_chg = 0;
        ex_chg = 0;
        chk("both_valid", 32'(fetch_valid), 32'd0);
        chk("both_addr", addr, 32'h2000);
        chk("both_req", 32'(req), 32'd1);
        run_until(32'h2008);
        expect_range(32'h2000, 2);
        ex_chg = 1;
        ex_pc = 32'h2003;
        tick();
        ex_chg = 0;
        chk("align_addr", addr, 32'h2000);
        chk("align_valid", 32'(fetch_valid), 32'd0);
        run_until(32'h2008);
        // flush with three entries replays from the head
        stall = 1;
        for (int k = 0; k < 20 && occupancy != 3'd3; k++) tick();
        chk("pre_flush_occ", 32'(occupancy), 32'd3);
        chk("pre_flush_pc", pc, 32'h2008);
        flush = 1;
        expect_range(32'h2008, 4);
        tick();
        flush = 0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_valid", 32'(fetch_valid), 32'd0);
        chk("flush_addr", addr, 32'h2008);
        chk("flush_pc", pc, 32'h2008);
        stall = 0;
        run_until(32'h2018);
        // asynchronous reset in the middle of a request
        stall = 1;
        lat = 2;
        wait_pending();
        #2 rst = 0;
        extra_ack = 1;
        #1;
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_req", 32'(req), 32'd0);
        chk("arst_valid", 32'(fetch_valid), 32'd0);
        chk("arst_addr", addr, 32'h1000);
        chk("arst_instr", fetch_instr, 32'h13);
        tick();
        rst = 1;
        lat = 1;
        stall = 0;
        expect_range(32'h1000, 4);
        tick();
        chk("late_ack_occ", 32'(occupancy), 32'd0);
        chk("restart_req", 32'(req), 32'd1);
        chk("restart_addr", addr, 32'h1000);
        extra_ack = 0;
        run_until(32'h1010);
        stall = 1;
        repeat (3) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
